instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h00000000, as the first fetch address after reset.
REQ-002 The block SHALL provide parameter BUF_DEPTH, default 2, as the instruction buffer entry count; only the power-of-two values 2 and 4 are legal.
REQ-003 The block SHALL provide port clk, input, 1 bit, as the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit, as the synchronous active-high reset.
REQ-005 The block SHALL provide port imem_addr, output, 32 bits, as the byte address driven to combinational instruction memory.
REQ-006 The block SHALL provide port imem_instr, input, 32 bits, as the instruction word returned by memory in the same cycle.
REQ-007 The block SHALL provide port redirect_valid, input, 1 bit, as the branch/jump redirect request.
REQ-008 The block SHALL provide port redirect_pc, input, 32 bits, as the redirect target address.
REQ-009 The block SHALL provide port out_valid, output, 1 bit, as the instruction-available flag to decode.
REQ-010 The block SHALL provide port out_ready, input, 1 bit, as the decode-accepts flag.
REQ-011 The block SHALL provide port out_instr, output, 32 bits, as the head instruction.
REQ-012 The block SHALL provide port out_pc, output, 32 bits, as the PC of the head instruction.
REQ-013 The block SHALL provide port fetch_fault, output, 1 bit, as the misaligned-target flag; it SHALL be tied to 0 when REQ-030 is off.

Function
REQ-014 The block SHALL drive imem_addr from the pc register at all times.
REQ-015 The block SHALL issue a fetch in a cycle when all three hold: the buffer is not full or a pop occurs, redirect_valid=0 and fetch_fault=0.
REQ-016 On a fetch, the block SHALL write {imem_instr, pc} into the buffer tail and set pc to pc+4, wrapping modulo 2^32.
REQ-017 Latency: an instruction fetched in cycle N SHALL be visible on out_valid/out_instr/out_pc in cycle N+1.
REQ-018 A pop SHALL occur iff out_valid and out_ready are both 1.
REQ-019 out_instr and out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 When the buffer is empty, out_valid SHALL be 0, out_instr SHALL be 32'h00000013 (NOP) and out_pc SHALL hold its last value.
REQ-021 When the buffer is full with no pop, there SHALL be no fetch, and pc SHALL hold.
REQ-022 When full with a pop in the same cycle, the block SHALL pop and fetch together and the occupancy SHALL be unchanged.
REQ-023 A redirect SHALL take priority over a fetch and over a pop: the buffer is flushed, pc is set to redirect_pc, and out_valid=0 in the next cycle.
REQ-024 Any pop handshake in a redirect cycle SHALL be treated as not accepted; decode discards that cycle's instruction.
REQ-025 The first instruction from the target SHALL appear 2 cycles after the redirect cycle.
REQ-026 Buffer pointers SHALL wrap modulo BUF_DEPTH, and occupancy SHALL never exceed BUF_DEPTH or go below 0.

Reset
REQ-027 While rst=1, the block SHALL set pc=RESET_PC, empty the buffer, and set out_valid=0, out_instr=NOP, out_pc=RESET_PC and fetch_fault=0.
REQ-028 There SHALL be no fetch in a reset cycle; the first fetch SHALL occur in the first cycle with rst=0.
REQ-029 Reset asserted mid-stream SHALL discard all buffered instructions, and reset SHALL override redirect.

Configuration
REQ-030 With macro FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set fetch_fault=1, load pc, flush the buffer, and halt fetching.
REQ-031 With FETCH_MISALIGN_TRAP_EN defined, fetch_fault SHALL be sticky until reset or an aligned redirect.
REQ-032 Without FETCH_MISALIGN_TRAP_EN, the block SHALL load redirect_pc with bits [1:0] forced to 0, and fetch_fault SHALL be 0.

Structure
REQ-033 The shared package rv_pkg SHALL hold the constants NOP_INSTR (32'h00000013), XLEN (32) and INSTR_BYTES (4).
REQ-034 The buffer SHALL be one sub-module, fetch_buf: a synchronous FIFO with push, pop, flush, full and empty ports, with flush taking priority over push.

Verification
REQ-035 Reset release with out_ready=1 and memory words 0x00000093, 0x00100113, ... SHALL give out_valid in cycle 1 with out_pc 0x0, then 0x4, 0x8 on consecutive cycles.
REQ-036 With out_ready=0 for 5 cycles, exactly BUF_DEPTH fetches SHALL occur, imem_addr SHALL hold at RESET_PC+4*BUF_DEPTH, and the head SHALL stay at pc 0x0.
REQ-037 Redirect to 0x40 while the buffer holds 2 entries SHALL give out_valid=0 the next cycle, then out_pc=0x40, with no stale pc ever popped.
REQ-038 Redirect and pop in the same cycle SHALL give a flush winning and no pop counted; the subsequent out_pc SHALL be the target.
REQ-039 Redirect to 0x42 SHALL raise fetch_fault with the macro and halt fetching, and SHALL produce a fetch at 0x40 without the macro.
REQ-040 A pc starting at 0xFFFFFFFC with RESET_PC set accordingly SHALL wrap to 0x00000000 on the next fetch.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: constants and the buffer entry type shared by the fetch unit.
//   NOP_INSTR   - canonical RV32 NOP (addi x0,x0,0), shown when nothing is buffered
//   XLEN        - data/address width
//   INSTR_BYTES - PC increment per fetched instruction
package rv_pkg;

  localparam int          XLEN        = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: synchronous FIFO holding {instr, pc} pairs between fetch and decode.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   flush         - drop all entries; wins over push and pop
//   push, wdata   - enqueue at tail (accepted when not full, or full with a pop)
//   pop           - dequeue head (ignored when empty)
//   rdata         - head entry (undefined contents when empty)
//   full, empty   - occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_buf
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation and instruction buffering in front of decode.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   imem_addr / imem_instr     - combinational instruction memory (same-cycle data)
//   redirect_valid/redirect_pc - branch/jump redirect; flushes and reloads pc
//   out_valid/out_ready        - valid/ready handshake to decode
//   out_instr/out_pc           - head instruction and its PC (NOP / last PC when empty)
//   fetch_fault                - misaligned redirect target seen (trap build only)
// Build option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets;
// otherwise the target's low two bits are cleared.
// BUF_DEPTH must be 2 or 4.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  logic [XLEN-1:0] pc, last_pc, target;
  logic            fault;
  logic            full, empty, pop, fetch;
  fetch_entry_t    head, tail;

  // A redirect cancels any handshake in the same cycle, so decode must
  // discard whatever it saw then.
  assign pop   = out_valid & out_ready & ~redirect_valid;
  assign fetch = (~full | pop) & ~redirect_valid & ~fault;

  assign tail.instr = imem_instr;
  assign tail.pc    = pc;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fetch),
    .pop   (pop),
    .wdata (tail),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr   = pc;
  assign out_valid   = ~empty;
  assign out_instr   = empty ? NOP_INSTR : head.instr;
  // last_pc tracks whatever was shown last so out_pc holds across empty cycles.
  assign out_pc      = empty ? last_pc : head.pc;
  assign fetch_fault = fault;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target = redirect_pc;

  // Sticky until reset or the next redirect, which re-evaluates alignment.
  always_ff @(posedge clk) begin
    if (rst)                 fault <= 1'b0;
    else if (redirect_valid) fault <= |redirect_pc[1:0];
  end
`else
  assign target = redirect_pc & ~32'h3;
  assign fault  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      last_pc <= RESET_PC;
    end else begin
      last_pc <= out_pc;
      if (redirect_valid) pc <= target;
      else if (fetch)     pc <= pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table covering streaming,
// stall, full+pop, redirect (with and without a same-cycle pop), misaligned
// redirect and mid-stream reset, plus short sequences for the stall fetch count
// at two buffer depths and PC wraparound.
module tb_instr_fetch;
  import rv_pkg::*;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        efault;
  } vec_t;

  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, fetch_fault;

  logic [31:0] d4_addr, d4_instr, d4_oinstr, d4_opc;
  logic        d4_valid, d4_fault;

  logic        w_rst;
  logic [31:0] w_addr, w_instr, w_oinstr, w_opc;
  logic        w_valid, w_fault;

  int checks = 0;
  int failures = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {2'b00, a[31:2]};
    return 32'h0000_0093 + idx * 32'h0010_0080;
  endfunction

  assign imem_instr = mem_word(imem_addr);
  assign d4_instr   = mem_word(d4_addr);
  assign w_instr    = mem_word(w_addr);

  instr_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  instr_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .imem_addr(d4_addr), .imem_instr(d4_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(d4_valid), .out_ready(out_ready), .out_instr(d4_oinstr),
    .out_pc(d4_opc), .fetch_fault(d4_fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dutw (
    .clk(clk), .rst(w_rst), .imem_addr(w_addr), .imem_instr(w_instr),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_oinstr),
    .out_pc(w_opc), .fetch_fault(w_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic r, input logic rv, input logic [31:0] rpc,
                      input logic rdy, input logic ev, input logic [31:0] epc,
                      input logic [31:0] eaddr, input logic ef);
    vecs[i].rst = r;   vecs[i].rv = rv;   vecs[i].rpc = rpc;     vecs[i].rdy = rdy;
    vecs[i].ev  = ev;  vecs[i].epc = epc; vecs[i].eaddr = eaddr; vecs[i].efault = ef;
  endtask

  initial begin
    int nfetch, nfetch4;
    logic [31:0] prev, prev4;

    //        rst rv  rpc     rdy  ev  epc     addr    fault
    setv( 0, 0, 0, 32'h0,  1,   0, 32'h0,  32'h0,  0);
    setv( 1, 0, 0, 32'h0,  1,   1, 32'h0,  32'h4,  0);
    setv( 2, 0, 0, 32'h0,  1,   1, 32'h4,  32'h8,  0);
    setv( 3, 0, 0, 32'h0,  0,   1, 32'h8,  32'hC,  0);
    setv( 4, 0, 0, 32'h0,  0,   1, 32'h8,  32'h10, 0);
    setv( 5, 0, 0, 32'h0,  0,   1, 32'h8,  32'h10, 0);
    setv( 6, 0, 0, 32'h0,  1,   1, 32'h8,  32'h10, 0);
    setv( 7, 0, 1, 32'h40, 1,   1, 32'hC,  32'h14, 0);
    setv( 8, 0, 0, 32'h0,  1,   0, 32'hC,  32'h40, 0);
    setv( 9, 0, 0, 32'h0,  1,   1, 32'h40, 32'h44, 0);
    setv(10, 0, 1, 32'h42, 0,   1, 32'h44, 32'h48, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    setv(11, 0, 0, 32'h0,  1,   0, 32'h44, 32'h42, 1);
    setv(12, 0, 0, 32'h0,  1,   0, 32'h44, 32'h42, 1);
    setv(13, 0, 1, 32'h80, 1,   0, 32'h44, 32'h42, 1);
`else
    setv(11, 0, 0, 32'h0,  1,   0, 32'h44, 32'h40, 0);
    setv(12, 0, 0, 32'h0,  1,   1, 32'h40, 32'h44, 0);
    setv(13, 0, 1, 32'h80, 1,   1, 32'h44, 32'h48, 0);
`endif
    setv(14, 0, 0, 32'h0,  1,   0, 32'h44, 32'h80, 0);
    setv(15, 0, 0, 32'h0,  1,   1, 32'h80, 32'h84, 0);
    setv(16, 1, 1, 32'h100,1,   1, 32'h84, 32'h88, 0);
    setv(17, 0, 0, 32'h0,  0,   0, 32'h0,  32'h0,  0);
    setv(18, 0, 0, 32'h0,  0,   1, 32'h0,  32'h4,  0);

    rst = 1'b1; w_rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, NOP_INSTR);
    chk("rst_pc",    out_pc, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      #2;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("v%0d_pc", i),    out_pc, vecs[i].epc);
      chk($sformatf("v%0d_instr", i), out_instr,
          vecs[i].ev ? mem_word(vecs[i].epc) : NOP_INSTR);
      chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].efault});
      @(posedge clk); #1;
    end

    // Stall for 5 cycles from reset: each depth fills exactly once and stops.
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    prev = imem_addr; prev4 = d4_addr; nfetch = 0; nfetch4 = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (imem_addr != prev) nfetch++;
      if (d4_addr != prev4)  nfetch4++;
      prev = imem_addr; prev4 = d4_addr;
    end
    chk("stall_fetches_d2", nfetch, 2);
    chk("stall_addr_d2",    imem_addr, 32'h8);
    chk("stall_head_d2",    out_pc, 32'h0);
    chk("stall_fetches_d4", nfetch4, 4);
    chk("stall_addr_d4",    d4_addr, 32'h10);
    chk("stall_head_d4",    d4_opc, 32'h0);
    chk("stall_valid_d4",   {31'b0, d4_valid}, 32'h1);

    // PC wraparound from the top of the address space.
    w_rst = 1'b0;
    #1;
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_valid", {31'b0, w_valid}, 32'h1);
    chk("wrap_pc",    w_opc, 32'hFFFF_FFFC);
    chk("wrap_instr", w_oinstr, mem_word(32'hFFFF_FFFC));
    @(posedge clk); #1;
    chk("wrap_pc_next", w_opc, 32'h0);
    chk("wrap_fault",   {31'b0, w_fault}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
